riscv_control: RTL and testbench
================================

// Module: riscv_control
// PURPOSE
//  RV32I main decoder for the single-cycle datapath; sits between instruction fetch and the datapath muxes.
//  - Maps opcode/func3/func7 to ALU op, register-file write enable, immediate format, operand/writeback muxes and next-PC select.
//  - Resolves conditional branches from the ALU compare result in the same cycle.
// PARAMETERS
//  none (encodings are fixed constants in control_pkg)
// PORTS
//  clk                           in   1   clock
//  rst_n                         in   1   async active-low reset
//  opcode                        in   7   instr[6:0]
//  func3                         in   5   func3[2:0]=instr[14:12]; [4:3] ignored
//  func7                         in   5   instr[31:27]; func7[3]=instr[30] alt-op bit, others ignored
//  branch_result                 in   32  ALU compare output; branch taken when bit0=1, [31:1] ignored
//  size_sel                      out  2   mem access size: 00 byte, 01 half, 10 word
//  operation_sel                 out  4   ALU op (table below)
//  enable_write                  out  1   register-file write enable
//  PC_genrator_sel               out  2   00 PC+4, 01 PC+imm, 10 hold PC, 11 reserved (treated as hold)
//  imm_sel                       out  32  one-hot imm format: b0 I, b1 S, b2 B, b3 U, b4 J; [31:5]=0; all-0 = none
//  rs2_or_imm_or_4               out  2   ALU B: 00 rs2, 01 imm, 10 const 4
//  PC_or_Address                 out  1   next PC: 0 PC-generator output, 1 JALR target (rs1+imm, bit0 cleared)
//  PC_or_rs1                     out  1   ALU A: 0 rs1, 1 PC
//  ALU_or_load_or_immShiftedBy12 out  2   writeback: 00 ALU, 01 load data, 10 U-imm (imm<<12)
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-low. Only state is a 1-bit 'run' flop.
//    - rst_n=0 clears run asynchronously. Set on the first clk rise with rst_n=1.
//    - While run=0: all outputs = NOP, except PC_genrator_sel=10 (hold). Write is disabled through reset and the first cycle after release.
//    - Reset asserted mid-instruction forces hold-NOP immediately.
//  - run=1: fully combinational decode, 0-cycle latency.
//  - NOP values: size_sel=10, operation_sel=0000, enable_write=0, PC_genrator_sel=00, imm_sel=0, all mux selects 0.
//  - ALU ops: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, A EQ, B NE, C LT, D GE, E LTU, F GEU.
//  - R 0110011: wr=1, A=rs1, B=rs2, wb=ALU.
//    - f3 000: ADD, or SUB if func7[3]. 001 SLL. 010 SLT. 011 SLTU. 100 XOR.
//    - f3 101: SRL, or SRA if func7[3]. 110 OR. 111 AND.
//  - I-ALU 0010011: as R, but B=imm, imm I; f3 000 is always ADD.
//  - LOAD 0000011: wr=1, ADD, B=imm, imm I, wb=load, size_sel=func3[1:0]. Sign/zero extension is handled in the memory stage.
//  - STORE 0100011: wr=0, ADD, B=imm, imm S, size_sel=func3[1:0]. The memory write strobe is decoded in the memory interface.
//  - BRANCH 1100011: wr=0, A=rs1, B=rs2, imm B.
//    - f3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
//    - PC_genrator_sel = branch_result[0] ? 01 : 00.
//  - JAL 1101111: wr=1, A=PC, B=4, ADD, wb=ALU, imm J, PC_genrator_sel=01.
//  - JALR 1100111: wr=1, A=PC, B=4, ADD, wb=ALU, imm I, PC_or_Address=1.
//  - LUI 0110111: wr=1, imm U, wb=U-imm.
//  - AUIPC 0010111: wr=1, A=PC, B=imm, ADD, imm U, wb=ALU.
//  - Any other opcode: NOP, PC advances by 4.
// CONFIGURATION
//  RISCV_CONTROL_ILLEGAL_NOP_EN
//    - defined: illegal sub-encodings decode as NOP (PC+4, wr=0).
//      - Branch f3 010/011. Load f3 011/110/111. Store f3 >=011. JALR f3!=000.
//      - R-type func7[3]=1 with f3 not 000/101. I-type shift with func7[3]=1 on f3 001.
//    - undefined: decode by opcode only, func3 used as-is; load/store f3 011 decodes as word, branch f3 010/011 decodes as EQ/NE.
// STRUCTURE
//  - control_pkg: opcode localparams, ALU op codes, imm-format bit positions, PC/operand/writeback select encodings.
//  - Sub-module riscv_alu_decode: (opcode class, func3, func7[3]) -> operation_sel. Top holds the run flop, main decode and branch resolve.
// TESTING
//  - rst_n=0, then released: PC_genrator_sel=10, enable_write=0 until the first clk rise; then ADD (R, f3 0) -> op 0000, wr=1, B=00, wb=00.
//  - R f3 000 func7=01000 -> op 0001. I-type f3 101 func7=01000 -> op 0111, B=01, imm_sel=1.
//  - BEQ with branch_result=1 -> op 1010, PC_gen=01, imm_sel=4. Same with branch_result=32'hFFFFFFFE -> PC_gen=00.
//  - LH 0000011 f3 001 -> size 01, wb 01, wr 1. SW 0100011 f3 010 -> size 10, wr 0, imm_sel=2.
//  - JAL -> PC_gen 01, A=1, B=10, imm_sel=16. JALR -> PC_or_Address=1, imm_sel=1. LUI -> wb 10, imm_sel=8.
//  - opcode 7'h7F -> NOP. Load f3 111 -> NOP only with RISCV_CONTROL_ILLEGAL_NOP_EN defined.

Source files
------------

// File: rtl/riscv_control_pkg.sv
// control_pkg: fixed encodings shared by the RV32I main decoder.
//   - opcode values and the opcode classification helper
//   - ALU operation codes driven on operation_sel
//   - imm_sel one-hot bit positions
//   - PC-generator, ALU-B, writeback and memory-size select encodings
// Optional feature macro used by the decoder: RISCV_CONTROL_ILLEGAL_NOP_EN
package control_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        CLS_NONE, CLS_R, CLS_I, CLS_LOAD, CLS_STORE,
        CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC
    } op_class_e;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SLL  = 4'h2;
    localparam logic [3:0] ALU_SLT  = 4'h3;
    localparam logic [3:0] ALU_SLTU = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_OR   = 4'h8;
    localparam logic [3:0] ALU_AND  = 4'h9;
    localparam logic [3:0] ALU_EQ   = 4'hA;
    localparam logic [3:0] ALU_NE   = 4'hB;
    localparam logic [3:0] ALU_LT   = 4'hC;
    localparam logic [3:0] ALU_GE   = 4'hD;
    localparam logic [3:0] ALU_LTU  = 4'hE;
    localparam logic [3:0] ALU_GEU  = 4'hF;

    localparam int IMM_I = 0;
    localparam int IMM_S = 1;
    localparam int IMM_B = 2;
    localparam int IMM_U = 3;
    localparam int IMM_J = 4;

    localparam logic [1:0] PCG_SEQ  = 2'b00;
    localparam logic [1:0] PCG_IMM  = 2'b01;
    localparam logic [1:0] PCG_HOLD = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_UIMM = 2'b10;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    // func3[1:0]=11 has no size of its own; it is treated as a word access.
    function automatic logic [1:0] mem_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b11) ? SIZE_WORD : f3[1:0];
    endfunction

    function automatic op_class_e classify(input logic [6:0] opcode);
        case (opcode)
            OPC_R:      return CLS_R;
            OPC_I:      return CLS_I;
            OPC_LOAD:   return CLS_LOAD;
            OPC_STORE:  return CLS_STORE;
            OPC_BRANCH: return CLS_BRANCH;
            OPC_JAL:    return CLS_JAL;
            OPC_JALR:   return CLS_JALR;
            OPC_LUI:    return CLS_LUI;
            OPC_AUIPC:  return CLS_AUIPC;
            default:    return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu_decode.sv
// riscv_alu_decode: ALU operation select from opcode class, func3 and the
// alternate-op bit (instr[30]).
//   op_class      in  opcode class (control_pkg::op_class_e)
//   func3         in  instr[14:12]
//   alt           in  instr[30]
//   operation_sel out ALU op code
module riscv_alu_decode
    import control_pkg::*;
(
    input  op_class_e  op_class,
    input  logic [2:0] func3,
    input  logic       alt,
    output logic [3:0] operation_sel
);

    always_comb begin
        operation_sel = ALU_ADD;
        case (op_class)
            CLS_R, CLS_I: begin
                case (func3)
                    3'b000: operation_sel = (alt && op_class == CLS_R) ? ALU_SUB : ALU_ADD;
                    3'b001: operation_sel = ALU_SLL;
                    3'b010: operation_sel = ALU_SLT;
                    3'b011: operation_sel = ALU_SLTU;
                    3'b100: operation_sel = ALU_XOR;
                    3'b101: operation_sel = alt ? ALU_SRA : ALU_SRL;
                    3'b110: operation_sel = ALU_OR;
                    default: operation_sel = ALU_AND;
                endcase
            end
            CLS_BRANCH: begin
                // 010/011 have no branch meaning; they fall back to EQ/NE via func3[0].
                case (func3)
                    3'b100: operation_sel = ALU_LT;
                    3'b101: operation_sel = ALU_GE;
                    3'b110: operation_sel = ALU_LTU;
                    3'b111: operation_sel = ALU_GEU;
                    default: operation_sel = func3[0] ? ALU_NE : ALU_EQ;
                endcase
            end
            default: operation_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_control.sv
// riscv_control: RV32I main decoder for the single-cycle datapath.
//   clk, rst_n                       clock, async active-low reset
//   opcode/func3/func7               instruction fields (func3[4:3] and func7 except bit 3 ignored)
//   branch_result                    ALU compare result, bit 0 = taken
//   size_sel                         memory access size
//   operation_sel                    ALU op
//   enable_write                     register-file write enable
//   PC_genrator_sel                  PC+4 / PC+imm / hold
//   imm_sel                          one-hot immediate format
//   rs2_or_imm_or_4                  ALU B select
//   PC_or_Address                    next PC from PC generator or JALR target
//   PC_or_rs1                        ALU A select
//   ALU_or_load_or_immShiftedBy12    writeback select
// Optional: RISCV_CONTROL_ILLEGAL_NOP_EN makes illegal sub-encodings decode as NOP.
//
// run | meaning
// ----+-------------------------------------------------------
//  0  | in/just out of reset: hold PC, everything else NOP
//  1  | decoding instructions combinationally
module riscv_control
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [4:0]  func3,
    input  logic [4:0]  func7,
    input  logic [31:0] branch_result,
    output logic [1:0]  size_sel,
    output logic [3:0]  operation_sel,
    output logic        enable_write,
    output logic [1:0]  PC_genrator_sel,
    output logic [31:0] imm_sel,
    output logic [1:0]  rs2_or_imm_or_4,
    output logic        PC_or_Address,
    output logic        PC_or_rs1,
    output logic [1:0]  ALU_or_load_or_immShiftedBy12
);

    logic       run;
    logic       run_next;
    logic       illegal;
    logic [2:0] f3;
    logic       alt;
    logic [3:0] alu_op;
    op_class_e  op_class;
    logic       unused_bits;

    assign f3          = func3[2:0];
    assign alt         = func7[3];
    assign op_class    = classify(opcode);
    assign unused_bits = ^{func3[4:3], func7[4], func7[2:0], branch_result[31:1]};

    riscv_alu_decode u_alu_decode (
        .op_class      (op_class),
        .func3         (f3),
        .alt           (alt),
        .operation_sel (alu_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= run_next;
    end

    always_comb begin
        run_next = 1'b1;
    end

`ifdef RISCV_CONTROL_ILLEGAL_NOP_EN
    always_comb begin
        illegal = 1'b0;
        case (op_class)
            CLS_R:      illegal = alt && (f3 != 3'b000) && (f3 != 3'b101);
            CLS_I:      illegal = alt && (f3 == 3'b001);
            CLS_LOAD:   illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            CLS_STORE:  illegal = (f3 >= 3'b011);
            CLS_BRANCH: illegal = (f3 == 3'b010) || (f3 == 3'b011);
            CLS_JALR:   illegal = (f3 != 3'b000);
            default:    illegal = 1'b0;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        size_sel                      = SIZE_WORD;
        operation_sel                 = alu_op;
        enable_write                  = 1'b0;
        PC_genrator_sel               = PCG_SEQ;
        imm_sel                       = '0;
        rs2_or_imm_or_4               = SRC_B_RS2;
        PC_or_Address                 = 1'b0;
        PC_or_rs1                     = 1'b0;
        ALU_or_load_or_immShiftedBy12 = WB_ALU;

        if (!run) begin
            operation_sel   = ALU_ADD;
            PC_genrator_sel = PCG_HOLD;
        end else if (illegal) begin
            operation_sel = ALU_ADD;
        end else begin
            case (op_class)
                CLS_R: enable_write = 1'b1;
                CLS_I: begin
                    enable_write     = 1'b1;
                    rs2_or_imm_or_4  = SRC_B_IMM;
                    imm_sel[IMM_I]   = 1'b1;
                end
                CLS_LOAD: begin
                    enable_write                  = 1'b1;
                    rs2_or_imm_or_4               = SRC_B_IMM;
                    imm_sel[IMM_I]                = 1'b1;
                    ALU_or_load_or_immShiftedBy12 = WB_LOAD;
                    size_sel                      = mem_size(f3);
                end
                CLS_STORE: begin
                    rs2_or_imm_or_4 = SRC_B_IMM;
                    imm_sel[IMM_S]  = 1'b1;
                    size_sel        = mem_size(f3);
                end
                CLS_BRANCH: begin
                    imm_sel[IMM_B]  = 1'b1;
                    PC_genrator_sel = branch_result[0] ? PCG_IMM : PCG_SEQ;
                end
                CLS_JAL: begin
                    enable_write    = 1'b1;
                    PC_or_rs1       = 1'b1;
                    rs2_or_imm_or_4 = SRC_B_FOUR;
                    imm_sel[IMM_J]  = 1'b1;
                    PC_genrator_sel = PCG_IMM;
                end
                CLS_JALR: begin
                    enable_write    = 1'b1;
                    PC_or_rs1       = 1'b1;
                    rs2_or_imm_or_4 = SRC_B_FOUR;
                    imm_sel[IMM_I]  = 1'b1;
                    PC_or_Address   = 1'b1;
                end
                CLS_LUI: begin
                    enable_write                  = 1'b1;
                    imm_sel[IMM_U]                = 1'b1;
                    ALU_or_load_or_immShiftedBy12 = WB_UIMM;
                end
                CLS_AUIPC: begin
                    enable_write    = 1'b1;
                    PC_or_rs1       = 1'b1;
                    rs2_or_imm_or_4 = SRC_B_IMM;
                    imm_sel[IMM_U]  = 1'b1;
                end
                default: operation_sel = ALU_ADD;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_control.sv
// Self-checking bench for riscv_control: reset/hold sequences, a table of
// directed vectors, and random instructions against a table-based model.
module tb_riscv_control;

`ifdef RISCV_CONTROL_ILLEGAL_NOP_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  size;
        logic [3:0]  op;
        logic        wr;
        logic [1:0]  pcg;
        logic [31:0] imm;
        logic [1:0]  b;
        logic        pa;
        logic        pr;
        logic [1:0]  wb;
    } outs_t;

    typedef struct {
        string       name;
        logic [6:0]  opc;
        logic [4:0]  f3;
        logic [4:0]  f7;
        logic [31:0] br;
        outs_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'h33;
    logic [4:0]  func3 = 5'd0;
    logic [4:0]  func7 = 5'd0;
    logic [31:0] branch_result = 32'd0;
    outs_t       act;

    int vectors = 0;
    int miscompares = 0;

    riscv_control dut (
        .clk                           (clk),
        .rst_n                         (rst_n),
        .opcode                        (opcode),
        .func3                         (func3),
        .func7                         (func7),
        .branch_result                 (branch_result),
        .size_sel                      (act.size),
        .operation_sel                 (act.op),
        .enable_write                  (act.wr),
        .PC_genrator_sel               (act.pcg),
        .imm_sel                       (act.imm),
        .rs2_or_imm_or_4               (act.b),
        .PC_or_Address                 (act.pa),
        .PC_or_rs1                     (act.pr),
        .ALU_or_load_or_immShiftedBy12 (act.wb)
    );

    always #5 clk = ~clk;

    function automatic outs_t mk(int size, int op, int wr, int pcg, int imm,
                                 int b, int pa, int pr, int wb);
        outs_t o;
        o.size = 2'(size); o.op = 4'(op); o.wr = 1'(wr); o.pcg = 2'(pcg);
        o.imm = 32'(imm); o.b = 2'(b); o.pa = 1'(pa); o.pr = 1'(pr); o.wb = 2'(wb);
        return o;
    endfunction

    // Reference model built from the instruction tables.
    function automatic outs_t model(bit run, logic [6:0] opc, logic [4:0] f3w,
                                    logic [4:0] f7w, logic [31:0] br);
        int r_ops[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int b_ops[8] = '{10, 11, 10, 11, 12, 13, 14, 15};
        int f = int'(f3w[2:0]);
        bit alt = f7w[3];
        bit bad = 1'b0;
        outs_t nop = mk(2, 0, 0, 0, 0, 0, 0, 0, 0);
        outs_t o = nop;
        if (!run) begin
            o.pcg = 2;
            return o;
        end
        case (opc)
            7'h33: begin
                o = mk(2, r_ops[f] + ((alt && (f == 0 || f == 5)) ? 1 : 0), 1, 0, 0, 0, 0, 0, 0);
                bad = alt && f != 0 && f != 5;
            end
            7'h13: begin
                o = mk(2, r_ops[f] + ((alt && f == 5) ? 1 : 0), 1, 0, 1, 1, 0, 0, 0);
                bad = alt && f == 1;
            end
            7'h03: begin
                o = mk(((f % 4) > 2) ? 2 : (f % 4), 0, 1, 0, 1, 1, 0, 0, 1);
                bad = f == 3 || f >= 6;
            end
            7'h23: begin
                o = mk(((f % 4) > 2) ? 2 : (f % 4), 0, 0, 0, 2, 1, 0, 0, 0);
                bad = f >= 3;
            end
            7'h63: begin
                o = mk(2, b_ops[f], 0, br[0] ? 1 : 0, 4, 0, 0, 0, 0);
                bad = f == 2 || f == 3;
            end
            7'h6F: o = mk(2, 0, 1, 1, 16, 2, 0, 1, 0);
            7'h67: begin
                o = mk(2, 0, 1, 0, 1, 2, 1, 1, 0);
                bad = f != 0;
            end
            7'h37: o = mk(2, 0, 1, 0, 8, 0, 0, 0, 2);
            7'h17: o = mk(2, 0, 1, 0, 8, 1, 0, 1, 0);
            default: o = nop;
        endcase
        if (ILL_EN && bad) o = nop;
        return o;
    endfunction

    task automatic check(input string name, input outs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got size=%b op=%h wr=%b pcg=%b imm=%h b=%b pa=%b pr=%b wb=%b, want size=%b op=%h wr=%b pcg=%b imm=%h b=%b pa=%b pr=%b wb=%b",
                     name, act.size, act.op, act.wr, act.pcg, act.imm, act.b, act.pa, act.pr, act.wb,
                     exp.size, exp.op, exp.wr, exp.pcg, exp.imm, exp.b, exp.pa, exp.pr, exp.wb);
        end
    endtask

    task automatic drive(input logic [6:0] opc, input logic [4:0] f3w,
                         input logic [4:0] f7w, input logic [31:0] br);
        opcode = opc; func3 = f3w; func7 = f7w; branch_result = br;
    endtask

    vec_t vecs[$];
    outs_t hold;
    outs_t nop_o;

    initial begin
        hold  = mk(2, 0, 0, 2, 0, 0, 0, 0, 0);
        nop_o = mk(2, 0, 0, 0, 0, 0, 0, 0, 0);

        vecs.push_back('{"r_add",    7'h33, 5'b00000, 5'b00000, 32'h0,        mk(2, 0, 1, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"r_sub",    7'h33, 5'b00000, 5'b01000, 32'h0,        mk(2, 1, 1, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"r_sra",    7'h33, 5'b00101, 5'b01000, 32'h0,        mk(2, 7, 1, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"r_srl",    7'h33, 5'b00101, 5'b10111, 32'h0,        mk(2, 6, 1, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"i_srai",   7'h13, 5'b00101, 5'b01000, 32'h0,        mk(2, 7, 1, 0, 1, 1, 0, 0, 0)});
        vecs.push_back('{"i_addi",   7'h13, 5'b00000, 5'b01000, 32'h0,        mk(2, 0, 1, 0, 1, 1, 0, 0, 0)});
        vecs.push_back('{"beq_tk",   7'h63, 5'b00000, 5'b00000, 32'h1,        mk(2, 10, 0, 1, 4, 0, 0, 0, 0)});
        vecs.push_back('{"beq_nt",   7'h63, 5'b00000, 5'b00000, 32'hFFFFFFFE, mk(2, 10, 0, 0, 4, 0, 0, 0, 0)});
        vecs.push_back('{"bne_hi",   7'h63, 5'b11001, 5'b00000, 32'h1,        mk(2, 11, 0, 1, 4, 0, 0, 0, 0)});
        vecs.push_back('{"bgeu",     7'h63, 5'b00111, 5'b00000, 32'h0,        mk(2, 15, 0, 0, 4, 0, 0, 0, 0)});
        vecs.push_back('{"lh",       7'h03, 5'b00001, 5'b00000, 32'h0,        mk(1, 0, 1, 0, 1, 1, 0, 0, 1)});
        vecs.push_back('{"sw",       7'h23, 5'b00010, 5'b00000, 32'h0,        mk(2, 0, 0, 0, 2, 1, 0, 0, 0)});
        vecs.push_back('{"jal",      7'h6F, 5'b00000, 5'b00000, 32'h0,        mk(2, 0, 1, 1, 16, 2, 0, 1, 0)});
        vecs.push_back('{"jalr",     7'h67, 5'b00000, 5'b00000, 32'h0,        mk(2, 0, 1, 0, 1, 2, 1, 1, 0)});
        vecs.push_back('{"lui",      7'h37, 5'b00000, 5'b00000, 32'h0,        mk(2, 0, 1, 0, 8, 0, 0, 0, 2)});
        vecs.push_back('{"auipc",    7'h17, 5'b00000, 5'b00000, 32'h0,        mk(2, 0, 1, 0, 8, 1, 0, 1, 0)});
        vecs.push_back('{"opc_7f",   7'h7F, 5'b00000, 5'b00000, 32'h1,        nop_o});
        vecs.push_back('{"ld_f3_7",  7'h03, 5'b00111, 5'b00000, 32'h0,
                         ILL_EN ? nop_o : mk(2, 0, 1, 0, 1, 1, 0, 0, 1)});
        vecs.push_back('{"br_f3_2",  7'h63, 5'b00010, 5'b00000, 32'h1,
                         ILL_EN ? nop_o : mk(2, 10, 0, 1, 4, 0, 0, 0, 0)});
        vecs.push_back('{"st_f3_3",  7'h23, 5'b00011, 5'b00000, 32'h0,
                         ILL_EN ? nop_o : mk(2, 0, 0, 0, 2, 1, 0, 0, 0)});

        // Reset and release: hold until the first rising edge with rst_n high.
        drive(7'h33, 5'd0, 5'd0, 32'd0);
        #2;  check("rst_hold", hold);
        @(posedge clk); #1;
        check("rst_hold_edge", hold);
        @(negedge clk);
        rst_n = 1'b1;
        #1;  check("rel_hold", hold);
        @(posedge clk); #1;
        check("rel_add", mk(2, 0, 1, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].br);
            #1;
            check(vecs[i].name, vecs[i].exp);
        end

        // Reset dropped mid-instruction forces hold immediately.
        @(negedge clk);
        drive(7'h6F, 5'd0, 5'd0, 32'd0);
        #1;  check("jal_pre", mk(2, 0, 1, 1, 16, 2, 0, 1, 0));
        rst_n = 1'b0;
        #1;  check("mid_rst", hold);
        rst_n = 1'b1;
        #1;  check("mid_rel", hold);
        @(posedge clk); #1;
        check("mid_run", mk(2, 0, 1, 1, 16, 2, 0, 1, 0));

        for (int n = 0; n < 400; n++) begin
            logic [6:0] opcs[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
            int pick = int'($urandom_range(0, 10));
            logic [6:0] o = (pick < 9) ? opcs[pick] : 7'($urandom);
            @(negedge clk);
            drive(o, 5'($urandom), 5'($urandom), $urandom);
            #1;
            check("random", model(1'b1, opcode, func3, func7, branch_result));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
